// File: rtl/io_port_endpoint.sv
// rtl/io_port_endpoint.sv - ingress/egress word FIFOs between an external stream and a processor I/O port
// Optional sticky access-error outputs: define OCTAVO_IO_ENDPOINT_ERROR_EN.
module io_port_endpoint #(
    parameter int WORD_WIDTH = 36,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  io_read_EF,
    output logic [WORD_WIDTH-1:0] io_read_data,
    input  logic                  io_rden,
    output logic                  io_write_EF,
    input  logic [WORD_WIDTH-1:0] io_write_data,
    input  logic                  io_wren,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
    ,
    output logic                  rd_underrun,
    output logic                  wr_overrun
`endif
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [WORD_WIDTH-1:0] ing_mem [DEPTH];
    logic [WORD_WIDTH-1:0] egr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ing_wr_ptr, ing_rd_ptr, egr_wr_ptr, egr_rd_ptr;
    logic [ADDR_WIDTH:0]   ing_count, egr_count;
    logic                  ing_push, ing_pop, egr_push, egr_pop;

    // Flags come only from registered counts, so no input reaches them combinationally.
    assign in_ready    = (ing_count != FULL_COUNT);
    assign io_read_EF  = (ing_count != '0);
    assign io_write_EF = (egr_count != FULL_COUNT);
    assign out_valid   = (egr_count != '0);

    assign ing_push = in_valid & in_ready;
    assign ing_pop  = io_rden & io_read_EF;
    assign egr_push = io_wren & io_write_EF;
    assign egr_pop  = out_ready & out_valid;

    assign io_read_data = ing_mem[ing_rd_ptr];
    assign out_data     = egr_mem[egr_rd_ptr];

    // Storage is deliberately left out of reset; the counts alone say what is valid.
    always_ff @(posedge clock) begin
        if (ing_push) ing_mem[ing_wr_ptr] <= in_data;
        if (egr_push) egr_mem[egr_wr_ptr] <= io_write_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ing_wr_ptr <= '0;
            ing_rd_ptr <= '0;
            ing_count  <= '0;
        end else begin
            if (ing_push) ing_wr_ptr <= ing_wr_ptr + PTR_ONE;
            if (ing_pop)  ing_rd_ptr <= ing_rd_ptr + PTR_ONE;
            if (ing_push && !ing_pop)      ing_count <= ing_count + COUNT_ONE;
            else if (ing_pop && !ing_push) ing_count <= ing_count - COUNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            egr_wr_ptr <= '0;
            egr_rd_ptr <= '0;
            egr_count  <= '0;
        end else begin
            if (egr_push) egr_wr_ptr <= egr_wr_ptr + PTR_ONE;
            if (egr_pop)  egr_rd_ptr <= egr_rd_ptr + PTR_ONE;
            if (egr_push && !egr_pop)      egr_count <= egr_count + COUNT_ONE;
            else if (egr_pop && !egr_push) egr_count <= egr_count - COUNT_ONE;
        end
    end

`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
    // Sticky until reset so software can poll after the fact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_underrun <= 1'b0;
            wr_overrun  <= 1'b0;
        end else begin
            if (io_rden && !io_read_EF)  rd_underrun <= 1'b1;
            if (io_wren && !io_write_EF) wr_overrun  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_io_port_endpoint.sv
// tb/tb_io_port_endpoint.sv - scoreboard bench for io_port_endpoint
module tb_io_port_endpoint;
    localparam int W = 36;
    localparam int D = 4;
    localparam int A = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, io_read_EF, io_rden, io_write_EF, io_wren, out_valid, out_ready;
    logic [W-1:0] in_data, io_read_data, io_write_data, out_data;
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
    logic         rd_underrun, wr_overrun;
    bit           exp_rd_underrun = 0, exp_wr_overrun = 0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] ing_q[$];
    logic [W-1:0] egr_q[$];

    io_port_endpoint #(.WORD_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .io_read_EF(io_read_EF), .io_read_data(io_read_data), .io_rden(io_rden),
        .io_write_EF(io_write_EF), .io_write_data(io_write_data), .io_wren(io_wren),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
        , .rd_underrun(rd_underrun), .wr_overrun(wr_overrun)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the queue model,
    // then applies the transfers that the coming rising edge will perform.
    always @(negedge clock) begin
        bit ing_full, egr_full;
        check("in_ready",    in_ready,    ing_q.size() != D);
        check("io_read_EF",  io_read_EF,  ing_q.size() != 0);
        check("io_write_EF", io_write_EF, egr_q.size() != D);
        check("out_valid",   out_valid,   egr_q.size() != 0);
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
        check("rd_underrun", rd_underrun, exp_rd_underrun);
        check("wr_overrun",  wr_overrun,  exp_wr_overrun);
`endif
        if (!reset) begin
            ing_full = (ing_q.size() == D);
            egr_full = (egr_q.size() == D);
            if (io_rden && ing_q.size() != 0) begin
                check("io_read_data", io_read_data, ing_q[0]);
                void'(ing_q.pop_front());
            end
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
            else if (io_rden) exp_rd_underrun = 1;
`endif
            if (in_valid && !ing_full) ing_q.push_back(in_data);
            if (out_ready && egr_q.size() != 0) begin
                check("out_data", out_data, egr_q[0]);
                void'(egr_q.pop_front());
            end
            if (io_wren && !egr_full) egr_q.push_back(io_write_data);
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
            else if (io_wren) exp_wr_overrun = 1;
`endif
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic rd,
                         input logic wv, input logic [W-1:0] wd, input logic ordy);
        in_valid = iv; in_data = id; io_rden = rd;
        io_wren = wv; io_write_data = wd; out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom(), $urandom()});
    endfunction

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = '0; io_rden = 0; io_wren = 0; io_write_data = '0; out_ready = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // single word through ingress
        drive(1, 36'h000000011, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        drive(0, '0, 1, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);

        // fill ingress, fifth offer refused, drain in order
        for (int i = 1; i <= 5; i++) drive(1, W'(i), 0, 0, '0, 0);
        for (int i = 0; i < 4; i++)  drive(0, '0, 1, 0, '0, 0);

        // count held at 2 under simultaneous push/pop across pointer wrap
        drive(1, 36'h0000000A1, 0, 0, '0, 0);
        drive(1, 36'h0000000A2, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) drive(1, rand_word(), 1, 0, '0, 0);
        drive(0, '0, 1, 0, '0, 0);
        drive(0, '0, 1, 0, '0, 0);

        // egress: fill with consumer stalled, fifth write dropped, then drain
        drive(0, '0, 0, 1, 36'hABCDEF012, 0);
        for (int i = 0; i < 4; i++) drive(0, '0, 0, 1, rand_word(), 0);
        for (int i = 0; i < 4; i++) drive(0, '0, 0, 0, '0, 1);

        // read with nothing available
        drive(0, '0, 1, 0, '0, 0);
        drive(0, '0, 1, 0, '0, 0);

        // reset mid-cycle with ingress 3 and egress 2 buffered
        drive(1, 36'h000000B01, 0, 1, 36'h000000C01, 0);
        drive(1, 36'h000000B02, 0, 1, 36'h000000C02, 0);
        drive(1, 36'h000000B03, 0, 0, '0, 0);
        in_valid = 0; io_rden = 0; io_wren = 0; out_ready = 0;
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready",    in_ready,    1'b1);
        check("rst_io_read_EF",  io_read_EF,  1'b0);
        check("rst_io_write_EF", io_write_EF, 1'b1);
        check("rst_out_valid",   out_valid,   1'b0);
        ing_q.delete();
        egr_q.delete();
`ifdef OCTAVO_IO_ENDPOINT_ERROR_EN
        exp_rd_underrun = 0;
        exp_wr_overrun  = 0;
`endif
        @(posedge clock);
        #1 reset = 1'b0;

        // first push after reset is the new head
        drive(1, 36'h000000055, 0, 1, 36'h000000066, 0);
        drive(0, '0, 1, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 0);

        // random traffic on both directions
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom), rand_word(), 1'($urandom), 1'($urandom), rand_word(), 1'($urandom));

        drive(0, '0, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
